// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester arbiter and access sequencer for DataMemory
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_resp_valid,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0]            CNT_INIT = 2'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] WORDS    = ADDR_WIDTH'(MEM_SIZE);

    state_t                state, state_nxt;
    logic                  prio_b;
    logic                  own_b;
    logic                  lat_we;
    logic                  lat_err;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  gnt_a, gnt_b, hs;
    logic                  sel_we, sel_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Grant is purely combinational so ready can rise in the same cycle as valid.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        if (state == IDLE && !rst) begin
            gnt_a = a_req_valid && (!b_req_valid || !prio_b);
            gnt_b = b_req_valid && (!a_req_valid || prio_b);
        end
        hs        = gnt_a || gnt_b;
        sel_we    = gnt_b ? b_req_we    : a_req_we;
        sel_addr  = gnt_b ? b_req_addr  : a_req_addr;
        sel_wdata = gnt_b ? b_req_wdata : a_req_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[ADDR_WIDTH-1:2]} >= WORDS);
    end

    always_comb begin
        state_nxt    = state;
        a_req_ready  = gnt_a;
        b_req_ready  = gnt_b;
        mem_we       = 1'b0;
        a_resp_valid = 1'b0;
        b_resp_valid = 1'b0;
        resp_rdata   = '0;
        resp_err     = 1'b0;
        case (state)
            IDLE: begin
                if (hs) state_nxt = sel_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_we    = lat_we;
                state_nxt = (lat_we || RD_LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0) state_nxt = RESP;
            end
            RESP: begin
                a_resp_valid = !own_b;
                b_resp_valid = own_b;
                resp_rdata   = rdata_q;
                resp_err     = lat_err;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory address/data registers double as the transaction latch; mem_we gates their use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio_b    <= 1'b0;
            own_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            cnt       <= 2'd0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_raddr <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                prio_b  <= gnt_a;
                own_b   <= gnt_b;
                lat_we  <= sel_we;
                lat_err <= sel_err;
                rdata_q <= '0;
                if (!sel_err) begin
                    if (sel_we) begin
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end else begin
                        mem_raddr <= sel_addr;
                    end
                end
            end
            if (state == ACCESS && !lat_we) begin
                if (RD_LATENCY == 0) rdata_q <= mem_rdata;
                else                 cnt     <= CNT_INIT;
            end
            if (state == WAIT) begin
                if (cnt == 2'd0) rdata_q <= mem_rdata;
                else             cnt     <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;

    logic        a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic        a_ready, b_ready, a_resp, b_resp, resp_err, m_we;
    logic [31:0] resp_rdata, m_addr, m_wdata, m_raddr, m_rdata;

    logic        v6 = 0;
    logic [31:0] addr6 = 0;
    logic        l0_ready, l0_bready, l0_resp, l0_bresp, l0_err, l0_we;
    logic [31:0] l0_rdata, l0_addr, l0_wdata, l0_raddr, l0_mrdata;
    logic        l3_ready, l3_bready, l3_resp, l3_bresp, l3_err, l3_we;
    logic [31:0] l3_rdata, l3_addr, l3_wdata, l3_raddr, l3_mrdata;
    logic [31:0] d1, d2, d3;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_valid), .a_req_ready(a_ready), .a_req_we(a_we),
        .a_req_addr(a_addr), .a_req_wdata(a_wdata), .a_resp_valid(a_resp),
        .b_req_valid(b_valid), .b_req_ready(b_ready), .b_req_we(b_we),
        .b_req_addr(b_addr), .b_req_wdata(b_wdata), .b_resp_valid(b_resp),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_raddr(m_raddr), .mem_rdata(m_rdata)
    );

    dmem_arbiter #(.RD_LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst),
        .a_req_valid(v6), .a_req_ready(l0_ready), .a_req_we(1'b0),
        .a_req_addr(addr6), .a_req_wdata(32'h0), .a_resp_valid(l0_resp),
        .b_req_valid(1'b0), .b_req_ready(l0_bready), .b_req_we(1'b0),
        .b_req_addr(32'h0), .b_req_wdata(32'h0), .b_resp_valid(l0_bresp),
        .resp_rdata(l0_rdata), .resp_err(l0_err),
        .mem_we(l0_we), .mem_addr(l0_addr), .mem_wdata(l0_wdata),
        .mem_raddr(l0_raddr), .mem_rdata(l0_mrdata)
    );

    dmem_arbiter #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .a_req_valid(v6), .a_req_ready(l3_ready), .a_req_we(1'b0),
        .a_req_addr(addr6), .a_req_wdata(32'h0), .a_resp_valid(l3_resp),
        .b_req_valid(1'b0), .b_req_ready(l3_bready), .b_req_we(1'b0),
        .b_req_addr(32'h0), .b_req_wdata(32'h0), .b_resp_valid(l3_bresp),
        .resp_rdata(l3_rdata), .resp_err(l3_err),
        .mem_we(l3_we), .mem_addr(l3_addr), .mem_wdata(l3_wdata),
        .mem_raddr(l3_raddr), .mem_rdata(l3_mrdata)
    );

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i == 255) ? 32'h5EED03FC : 32'h0;
        end else if (m_we) begin
            mem[m_addr[11:2]] <= m_wdata;
        end
        m_rdata <= mem[m_raddr[11:2]];
        d1 <= mem[l3_raddr[11:2]];
        d2 <= d1;
        d3 <= d2;
        if (m_we) we_cnt <= we_cnt + 1;
    end

    assign l0_mrdata = mem[l0_raddr[11:2]];
    assign l3_mrdata = d3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc;
        // reset state, ready held low while rst even with a valid request
        a_valid = 1;
        cyc(); cyc();
        clr = 0;
        #2;
        chk("rst_ready", {a_ready, b_ready}, 0);
        chk("rst_resp", {a_resp, b_resp, resp_err, m_we}, 0);
        chk("rst_mem", m_addr | m_raddr | m_wdata | resp_rdata, 0);
        a_valid = 0;

        // 1: A write 0xABCD1234 -> 0x100
        cyc(); rst = 0;
        a_valid = 1; a_we = 1; a_addr = 32'h100; a_wdata = 32'hABCD1234;
        #2 chk("t1_ready", {a_ready, b_ready}, 2'b10);
        cyc(); a_valid = 0;
        #2 chk("t1_we", m_we, 1);
        chk("t1_addr", m_addr, 32'h100);
        chk("t1_wdata", m_wdata, 32'hABCD1234);
        chk("t1_noresp", {a_resp, b_resp}, 0);
        cyc();
        #2 chk("t1_resp", {a_resp, b_resp, resp_err, m_we}, 4'b1000);
        chk("t1_rdata", resp_rdata, 0);

        // 2: A read 0x100
        cyc();
        a_valid = 1; a_we = 0; a_addr = 32'h100;
        #2 chk("t2_ready", a_ready, 1);
        cyc(); a_valid = 0;
        #2 chk("t2_raddr1", m_raddr, 32'h100);
        chk("t2_we", m_we, 0);
        cyc();
        #2 chk("t2_raddr2", m_raddr, 32'h100);
        chk("t2_early", a_resp, 0);
        cyc();
        #2 chk("t2_resp", {a_resp, b_resp, resp_err}, 3'b100);
        chk("t2_rdata", resp_rdata, 32'hABCD1234);

        // 3: both requesters continuously valid from reset
        cyc(); rst = 1;
        cyc(); rst = 0;
        a_valid = 1; a_we = 1; a_addr = 32'h0; a_wdata = 32'h11;
        b_valid = 1; b_we = 1; b_addr = 32'h4; b_wdata = 32'h22;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            #2 chk($sformatf("t3_c%0d", i), {a_ready, b_ready, a_resp, b_resp},
                   {i % 6 == 0, i % 6 == 3, i % 6 == 2, i % 6 == 5});
        end
        cyc(); a_valid = 0; b_valid = 0;
        #2 chk("t3_mem0", mem[0], 32'h11);
        chk("t3_mem1", mem[1], 32'h22);

        // 4: B error accesses and top legal word
        wc = we_cnt;
        cyc();
        b_valid = 1; b_we = 0; b_addr = 32'h102;
        #2 chk("t4_ready_mis", b_ready, 1);
        cyc(); b_valid = 0;
        #2 chk("t4_resp_mis", {a_resp, b_resp, resp_err}, 3'b011);
        chk("t4_rdata_mis", resp_rdata, 0);
        cyc();
        b_valid = 1; b_addr = 32'h1000;
        #2 chk("t4_ready_oor", b_ready, 1);
        cyc(); b_valid = 0;
        #2 chk("t4_resp_oor", {a_resp, b_resp, resp_err}, 3'b011);
        chk("t4_rdata_oor", resp_rdata, 0);
        chk("t4_no_we", we_cnt, wc);
        cyc();
        b_valid = 1; b_addr = 32'hFFC;
        #2 chk("t4_ready_top", b_ready, 1);
        cyc(); b_valid = 0;
        cyc(); cyc();
        #2 chk("t4_resp_top", {b_resp, resp_err}, 2'b10);

        // 5: async reset during WAIT of an A read
        cyc();
        a_valid = 1; a_we = 0; a_addr = 32'h100;
        #2 chk("t5_ready", a_ready, 1);
        cyc(); a_valid = 0;
        cyc();
        #2 rst = 1; a_valid = 1; b_valid = 1;
        #1 chk("t5_rst_out", {a_ready, b_ready, a_resp, b_resp, resp_err, m_we}, 0);
        chk("t5_rst_addr", m_raddr | m_addr | m_wdata | resp_rdata, 0);
        cyc();
        #2 chk("t5_rst_hold", {a_ready, b_ready, a_resp}, 0);
        cyc(); rst = 0; a_valid = 0;
        b_valid = 1; b_we = 0; b_addr = 32'h4;
        #2 chk("t5_b_first", {a_ready, b_ready}, 2'b01);
        cyc(); b_valid = 0;
        cyc(); cyc();
        #2 chk("t5_b_resp", {a_resp, b_resp}, 2'b01);
        chk("t5_b_rdata", resp_rdata, 32'h22);

        // 6: latency 0 and 3 reads of 0x3FC
        cyc();
        v6 = 1; addr6 = 32'h3FC;
        #2 chk("t6_ready", {l0_ready, l3_ready}, 2'b11);
        for (int i = 1; i <= 5; i++) begin
            cyc(); v6 = 0;
            #2 chk($sformatf("t6_c%0d", i), {l0_resp, l3_resp}, {i == 2, i == 5});
            if (i == 2) chk("t6_l0_rdata", l0_rdata, 32'h5EED03FC);
            if (i == 5) chk("t6_l3_rdata", l3_rdata, 32'h5EED03FC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
